// File: rtl/led_pattern_ctrl.sv
// Front-panel LED bar sequencer: waterfall / bounce / blink / off with a speed-scaled step divider.
// Optional build macro LED_AUTO_CYCLE_EN: advance the mode automatically after AUTO_STEPS steps.
module led_pattern_ctrl #(
  parameter int                 BASE_DIV   = 5_000_000 - 1,
  parameter int                 LED_NUM    = 4,
  parameter logic [LED_NUM-1:0] INIT_STA   = 4'b1100,
  parameter int                 AUTO_STEPS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode_next,
  input  logic               speed_up,
  input  logic               speed_down,
  input  logic               pause_tgl,
  output logic [LED_NUM-1:0] led_sig,
  output logic [1:0]         mode,
  output logic [1:0]         speed,
  output logic               paused,
  output logic               tick_o
);

  localparam int              CNT_W   = $clog2((BASE_DIV + 1) * 8);
  localparam logic [CNT_W-1:0] BASE_P1 = CNT_W'(BASE_DIV + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    MODE_WATER  = 2'd0,
    MODE_BOUNCE = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_OFF    = 2'd3
  } mode_e;

  mode_e              mode_r;
  logic [1:0]         speed_r;
  logic               paused_r;
  logic               tick_r;
  logic               dir_up_r;
  logic [LED_NUM-1:0] led_r;
  logic [CNT_W-1:0]   cnt_r;

  logic [1:0]         shift_s;
  logic [CNT_W-1:0]   limit_s;
  logic               at_limit_s;
  logic               speed_inc_s;
  logic               speed_dec_s;
  logic               speed_chg_s;
  logic               step_s;
  logic               advance_s;
  mode_e              next_mode_s;
  logic [LED_NUM-1:0] step_led_s;
  logic               step_dir_s;

  function automatic logic [LED_NUM-1:0] seed_of(input mode_e m);
    logic [LED_NUM-1:0] s;
    case (m)
      MODE_WATER:  s = INIT_STA;
      MODE_BOUNCE: s = {{(LED_NUM-1){1'b0}}, 1'b1};
      MODE_BLINK:  s = {LED_NUM{1'b1}};
      MODE_OFF:    s = {LED_NUM{1'b0}};
      default:     s = {LED_NUM{1'b0}};
    endcase
    return s;
  endfunction

  // Divider limit and per-cycle event qualification; a mode or speed change swallows the step
  always_comb begin
    shift_s     = 2'd3 - speed_r;
    limit_s     = (BASE_P1 << shift_s) - CNT_ONE;
    at_limit_s  = (cnt_r == limit_s);
    speed_inc_s = speed_up && !speed_down && (speed_r != 2'd3);
    speed_dec_s = speed_down && !speed_up && (speed_r != 2'd0);
    speed_chg_s = speed_inc_s || speed_dec_s;
    step_s      = !paused_r && at_limit_s && !mode_next && !speed_chg_s;
    next_mode_s = mode_e'(mode_r + 2'd1);
  end

  // Pattern produced by one step in the current mode
  always_comb begin
    step_led_s = led_r;
    step_dir_s = dir_up_r;
    case (mode_r)
      MODE_WATER: step_led_s = {led_r[0], led_r[LED_NUM-1:1]};
      MODE_BOUNCE: begin
        if (dir_up_r) begin
          if (led_r[LED_NUM-1]) begin
            step_dir_s = 1'b0;
            step_led_s = led_r >> 1'b1;
          end else begin
            step_led_s = led_r << 1'b1;
          end
        end else begin
          if (led_r[0]) begin
            step_dir_s = 1'b1;
            step_led_s = led_r << 1'b1;
          end else begin
            step_led_s = led_r >> 1'b1;
          end
        end
      end
      MODE_BLINK: step_led_s = ~led_r;
      MODE_OFF:   step_led_s = led_r;
      default:    step_led_s = led_r;
    endcase
  end

`ifdef LED_AUTO_CYCLE_EN
  localparam int AUTO_W = $clog2(AUTO_STEPS + 1);

  logic [AUTO_W-1:0] auto_cnt_r;
  logic              auto_adv_s;

  // OFF freezes the auto counter, making OFF terminal until a manual advance
  always_comb begin
    auto_adv_s = step_s && (mode_r != MODE_OFF) && (auto_cnt_r == AUTO_W'(AUTO_STEPS - 1));
    advance_s  = mode_next || auto_adv_s;
  end

  // Steps taken in the current mode
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end else if (advance_s) begin
      auto_cnt_r <= {AUTO_W{1'b0}};
    end else if (step_s && (mode_r != MODE_OFF)) begin
      auto_cnt_r <= auto_cnt_r + {{(AUTO_W-1){1'b0}}, 1'b1};
    end else begin
      auto_cnt_r <= auto_cnt_r;
    end
  end
`else
  // Mode changes only on an explicit request
  always_comb begin
    advance_s = mode_next;
  end
`endif

  // Mode, speed, pause, divider and LED pattern state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_r   <= MODE_WATER;
      speed_r  <= 2'd2;
      paused_r <= 1'b0;
      tick_r   <= 1'b0;
      dir_up_r <= 1'b1;
      led_r    <= INIT_STA;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      paused_r <= paused_r ^ pause_tgl;
      tick_r   <= step_s;

      if (speed_inc_s) begin
        speed_r <= speed_r + 2'd1;
      end else if (speed_dec_s) begin
        speed_r <= speed_r - 2'd1;
      end else begin
        speed_r <= speed_r;
      end

      // Holding cnt while paused preserves the remaining interval across a pause
      if (mode_next || speed_chg_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (paused_r) begin
        cnt_r <= cnt_r;
      end else if (at_limit_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end

      if (advance_s) begin
        mode_r   <= next_mode_s;
        led_r    <= seed_of(next_mode_s);
        dir_up_r <= 1'b1;
      end else if (step_s) begin
        led_r    <= step_led_s;
        dir_up_r <= step_dir_s;
      end else begin
        led_r    <= led_r;
        dir_up_r <= dir_up_r;
      end
    end
  end

  assign led_sig = led_r;
  assign mode    = mode_r;
  assign speed   = speed_r;
  assign paused  = paused_r;
  assign tick_o  = tick_r;

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Controller for the desk-clock front-panel LED bar.
- Sequences LED_NUM LEDs through four display modes: waterfall, bounce, blink and off.
- Owns the step-rate divider and exposes a runtime speed setting and a pause control.
- Driven by one-cycle event pulses from the debounced key block; led_sig drives the pads directly.

Parameters:
- BASE_DIV, 5_000_000-1: base divider; step period = (BASE_DIV+1) << (3-speed) clk cycles.
- LED_NUM, 4: number of LEDs (≥2).
- INIT_STA, 4'b1100: waterfall seed pattern, LED_NUM bits wide.
- AUTO_STEPS, 16: steps per mode before auto-advance; used only with the optional feature.

Ports:
- clk  input  1  system clock (20 MHz)
- rst  input  1  asynchronous active-low reset
- mode_next  input  1  pulse: advance to next mode
- speed_up  input  1  pulse: speed+1
- speed_down  input  1  pulse: speed-1
- pause_tgl  input  1  pulse: toggle paused
- led_sig  output  LED_NUM  LED drive, registered
- mode  output  2  current mode: 0 WATER, 1 BOUNCE, 2 BLINK, 3 OFF
- speed  output  2  current speed level, 0 slowest to 3 fastest
- paused  output  1  pause state
- tick_o  output  1  one-cycle pulse on the edge where led_sig steps

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is asynchronous and active-low: rst low immediately forces all state to reset values.
- Reset values: led_sig=INIT_STA, mode=0, speed=2, paused=0, tick_o=0, step counter cnt=0, bounce dir=up, auto counter=0.
- Divider:
  - limit = ((BASE_DIV+1) << (3-speed)) - 1.
  - cnt width must hold (BASE_DIV+1)*8-1.
  - When not paused: if cnt==limit, then cnt<=0, a step occurs and tick_o=1 for that cycle; otherwise cnt<=cnt+1.
  - When paused: cnt holds, no steps occur, led_sig holds.
- Step rules, by mode:
  - WATER: rotate right, led <= {led[0], led[LED_NUM-1:1]}.
  - BOUNCE, dir up: if led[LED_NUM-1]=1, set dir=down and led<=led>>1; else led<=led<<1.
  - BOUNCE, dir down: if led[0]=1, set dir=up and led<=led<<1; else led<=led>>1.
  - BLINK: led <= ~led.
  - OFF: led stays 0. tick_o still pulses.
- mode_next:
  - mode <= mode+1, wrapping 3->0.
  - Loads the new mode's seed: WATER INIT_STA; BOUNCE 1 in bit 0 with dir=up; BLINK all ones; OFF all zeros.
  - Clears cnt and the auto counter. No step occurs that cycle.
- Speed changes:
  - speed_up saturates at 3; speed_down saturates at 0.
  - Any effective speed change clears cnt. No step occurs that cycle.
  - A saturated request (no effective change) is ignored and cnt is not cleared.
  - speed_up and speed_down in the same cycle: both ignored.
- Priority within one cycle: mode_next > speed change > divider step.
  - A suppressed step is lost, not deferred.
  - If mode_next and a speed change arrive together, both take effect and cnt is cleared.
- pause_tgl: toggles paused and is independent of the other inputs. pause_tgl together with mode_next applies both; the new seed is shown and held.
- Pause and resume: resume continues from the held cnt, so the remaining interval is preserved.
- Latency: each control pulse takes effect on the next rising edge. Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
- Macro: LED_AUTO_CYCLE_EN.
- Defined:
  - A step counter counts steps taken in the current mode.
  - When it reaches AUTO_STEPS, the mode advances exactly as for mode_next, on the same edge as that step. The step's pattern update is replaced by the new seed.
  - In OFF mode the auto counter is frozen, so OFF is terminal until mode_next.
  - A manual mode_next clears the counter.
- Undefined: no auto counter logic exists; mode changes only on mode_next. AUTO_STEPS is unused.

Test Plan (BASE_DIV=3, LED_NUM=4, INIT_STA=4'b1100 unless stated):
1. Release rst, no inputs -> led=1100, mode=0, speed=2; tick_o on the 8th edge; led=0110, then 0011, 1001, 1100 at 8-cycle spacing.
2. speed_up x2 -> speed=3, second pulse ignored, tick every 4 cycles. speed_down x4 -> speed=0, tick every 32 cycles. Both pulses in the same cycle -> speed unchanged.
3. mode_next -> mode=1, led=0001. Steps give 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. mode_next from mode 1 -> BLINK, 1111, 0000, 1111. Next -> OFF, led=0000 while tick_o keeps pulsing. Next -> mode=0, led=1100, cnt=0.
5. pause_tgl at cnt=5 -> no tick and led held for 100 cycles. pause_tgl again -> next tick after 2 more cycles (cnt 6, 7).
6. Assert rst mid-BOUNCE at speed 3 -> all reset values immediately, async. With LED_AUTO_CYCLE_EN and AUTO_STEPS=4: 4 WATER steps, then mode=1 and led=0001 on the 4th step edge.
